// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter and its fill sequencer.
package vram_pkg;

    localparam int VRAM_WIDTH  = 160;
    localparam int VRAM_HEIGHT = 90;
    localparam int VRAM_SIZE   = VRAM_WIDTH * VRAM_HEIGHT;
    localparam int ADDR_W      = 14;
    localparam int DATA_W      = 24;

    localparam logic [DATA_W-1:0] FILL_FG = 24'hFFFFFF;
    localparam logic [DATA_W-1:0] FILL_BG = 24'h000000;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its requesters and the RAM port.
// Optional statistics outputs exist only when VRAM_ARB_STATS_EN is defined.
interface vram_arbiter_if #(
    parameter int ADDR_W = vram_pkg::ADDR_W,
    parameter int DATA_W = vram_pkg::DATA_W
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              fill_start;
    logic              fill_invert;
    logic              fill_busy;
    logic              fill_done;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0]       stat_wr_stall;
    logic [15:0]       stat_fill_stall;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data,
               fill_start, fill_invert, ram_rdata,
        output rd_valid, rd_data, wr_ready, fill_busy, fill_done,
               ram_en, ram_we, ram_addr, ram_wdata,
               stat_wr_stall, stat_fill_stall
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data,
               fill_start, fill_invert, ram_rdata,
        input  rd_valid, rd_data, wr_ready, fill_busy, fill_done,
               ram_en, ram_we, ram_addr, ram_wdata,
               stat_wr_stall, stat_fill_stall
    );
`else
    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data,
               fill_start, fill_invert, ram_rdata,
        output rd_valid, rd_data, wr_ready, fill_busy, fill_done,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data,
               fill_start, fill_invert, ram_rdata,
        input  rd_valid, rd_data, wr_ready, fill_busy, fill_done,
               ram_en, ram_we, ram_addr, ram_wdata
    );
`endif

endinterface

// File: rtl/vram_fill_seq.sv
// Split-screen fill sequencer: walks every VRAM word once, left half BG and
// right half FG (swapped when invert is latched), pausing while stalled.
module vram_fill_seq
    import vram_pkg::*;
#(
    parameter int                VRAM_WIDTH  = vram_pkg::VRAM_WIDTH,
    parameter int                VRAM_HEIGHT = vram_pkg::VRAM_HEIGHT,
    parameter int                ADDR_W      = vram_pkg::ADDR_W,
    parameter int                DATA_W      = vram_pkg::DATA_W,
    parameter logic [DATA_W-1:0] FILL_FG     = vram_pkg::FILL_FG,
    parameter logic [DATA_W-1:0] FILL_BG     = vram_pkg::FILL_BG
) (
    input  logic              clk_pixel,
    input  logic              rst_n,
    input  logic              start,
    input  logic              invert,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    // state     | meaning
    // FILL_IDLE | waiting for start; done pulses here for one cycle after a fill
    // FILL_RUN  | one write per unstalled cycle at idx, until the last word

    localparam int                COL_W    = $clog2(VRAM_WIDTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VRAM_WIDTH * VRAM_HEIGHT - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(VRAM_WIDTH - 1);
    localparam logic [COL_W-1:0]  MID_COL  = COL_W'(VRAM_WIDTH / 2);

    fill_state_t       state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic              inv_q, inv_nxt;
    logic              done_nxt;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL_IDLE;
            idx   <= '0;
            col   <= '0;
            inv_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            col   <= col_nxt;
            inv_q <= inv_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        col_nxt   = col;
        inv_nxt   = inv_q;
        done_nxt  = 1'b0;
        case (state)
            FILL_IDLE: begin
                if (start) begin
                    state_nxt = FILL_RUN;
                    idx_nxt   = '0;
                    col_nxt   = '0;
                    inv_nxt   = invert;
                end
            end
            FILL_RUN: begin
                if (!stall) begin
                    idx_nxt = idx + 1'b1;
                    col_nxt = (col == LAST_COL) ? '0 : col + 1'b1;
                    if (idx == LAST_IDX) begin
                        state_nxt = FILL_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = FILL_IDLE;
        endcase
    end

    assign busy = (state == FILL_RUN);
    assign addr = idx;
    // Column exactly at the midpoint still belongs to the left (BG) half.
    assign data = ((col > MID_COL) ^ inv_q) ? FILL_FG : FILL_BG;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads beat the fill sequencer, which beats
// the write port. Define VRAM_ARB_STATS_EN to add saturating stall counters.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int                VRAM_WIDTH  = vram_pkg::VRAM_WIDTH,
    parameter int                VRAM_HEIGHT = vram_pkg::VRAM_HEIGHT,
    parameter int                ADDR_W      = vram_pkg::ADDR_W,
    parameter int                DATA_W      = vram_pkg::DATA_W,
    parameter logic [DATA_W-1:0] FILL_FG     = vram_pkg::FILL_FG,
    parameter logic [DATA_W-1:0] FILL_BG     = vram_pkg::FILL_BG
) (
    input  logic           clk_pixel,
    input  logic           rst_n,
    vram_arbiter_if.slave  bus
);

    logic              fill_busy;
    logic              fill_done;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              rd_valid_q;
    logic              wr_ready;

    vram_fill_seq #(
        .VRAM_WIDTH  (VRAM_WIDTH),
        .VRAM_HEIGHT (VRAM_HEIGHT),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .FILL_FG     (FILL_FG),
        .FILL_BG     (FILL_BG)
    ) u_fill_seq (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .start     (bus.fill_start),
        .invert    (bus.fill_invert),
        .stall     (bus.rd_req),
        .busy      (fill_busy),
        .done      (fill_done),
        .addr      (fill_addr),
        .data      (fill_data)
    );

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) rd_valid_q <= 1'b0;
        else        rd_valid_q <= bus.rd_req;
    end

    // Held low while reset is asserted so nothing is accepted out of reset.
    assign wr_ready = rst_n && !bus.rd_req && !fill_busy;

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (bus.rd_req) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.rd_addr;
        end else if (fill_busy) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = fill_addr;
            bus.ram_wdata = fill_data;
        end else if (bus.wr_valid && wr_ready) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = bus.wr_addr;
            bus.ram_wdata = bus.wr_data;
        end
    end

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = bus.ram_rdata;
    assign bus.wr_ready  = wr_ready;
    assign bus.fill_busy = fill_busy;
    assign bus.fill_done = fill_done;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stat_wr_q;
    logic [15:0] stat_fill_q;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_q   <= '0;
            stat_fill_q <= '0;
        end else if (bus.fill_start) begin
            stat_wr_q   <= '0;
            stat_fill_q <= '0;
        end else begin
            if (bus.wr_valid && !wr_ready && stat_wr_q != 16'hFFFF)
                stat_wr_q <= stat_wr_q + 16'd1;
            if (fill_busy && bus.rd_req && stat_fill_q != 16'hFFFF)
                stat_fill_q <= stat_fill_q + 16'd1;
        end
    end

    assign bus.stat_wr_stall   = stat_wr_q;
    assign bus.stat_fill_stall = stat_fill_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus queues expected read
// data; a negedge monitor pops and compares whenever rd_valid is seen.
module tb_vram_arbiter;

    logic clk_pixel = 1'b0;
    logic rst_n;

    always #5 clk_pixel = ~clk_pixel;

    vram_arbiter_if bus ();

    vram_arbiter dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    // Registered single-port RAM, one cycle read latency.
    logic [23:0] mem [0:16383];
    always @(posedge clk_pixel) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_pixel) begin
        if (rst_n && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 expected no read pending at %0t", $time);
            end else begin
                check("rd_data", {8'h0, bus.rd_data}, {8'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [23:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [13:0] a, input logic [23:0] d);
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        exp_q.push_back(d);
        tick();
        bus.rd_req = 1'b0;
    endtask

    int busy_cnt, done_cnt, bad_ready, rd_cycles;
    logic tog;

    initial begin
        rst_n           = 1'b0;
        bus.rd_req      = 1'b0;
        bus.rd_addr     = '0;
        bus.wr_valid    = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.fill_start  = 1'b0;
        bus.fill_invert = 1'b0;
        repeat (3) @(posedge clk_pixel);
        #1;
        check("rst_rd_valid",  {31'h0, bus.rd_valid},  32'h0);
        check("rst_fill_busy", {31'h0, bus.fill_busy}, 32'h0);
        check("rst_fill_done", {31'h0, bus.fill_done}, 32'h0);
        check("rst_ram_en",    {31'h0, bus.ram_en},    32'h0);
        check("rst_ram_we",    {31'h0, bus.ram_we},    32'h0);
        check("rst_ram_addr",  {18'h0, bus.ram_addr},  32'h0);
        check("rst_ram_wdata", {8'h0, bus.ram_wdata},  32'h0);
        check("rst_wr_ready",  {31'h0, bus.wr_ready},  32'h0);
        rst_n = 1'b1;
        tick();

        // Write handshake
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 14'd100;
        bus.wr_data  = 24'hABCDEF;
        #1;
        check("wr_ready",     {31'h0, bus.wr_ready},  32'h1);
        check("wr_ram_en",    {31'h0, bus.ram_en},    32'h1);
        check("wr_ram_we",    {31'h0, bus.ram_we},    32'h1);
        check("wr_ram_addr",  {18'h0, bus.ram_addr},  32'd100);
        check("wr_ram_wdata", {8'h0, bus.ram_wdata},  32'hABCDEF);
        tick();
        bus.wr_valid = 1'b0;
        do_write(14'd5, 24'h123456);
        do_write(14'd16383, 24'h0F0F0F);

        // Read latency
        bus.rd_req  = 1'b1;
        bus.rd_addr = 14'd5;
        #1;
        check("rd_wr_ready",  {31'h0, bus.wr_ready}, 32'h0);
        check("rd_ram_we",    {31'h0, bus.ram_we},   32'h0);
        check("rd_ram_addr",  {18'h0, bus.ram_addr}, 32'd5);
        exp_q.push_back(24'h123456);
        tick();
        bus.rd_req = 1'b0;
        do_read(14'd100, 24'hABCDEF);

        // Contention: read wins for three cycles, write lands on the fourth
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 14'd200;
        bus.wr_data  = 24'h55AA33;
        for (int i = 0; i < 3; i++) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = 14'd5;
            exp_q.push_back(24'h123456);
            #1;
            check("cont_wr_ready", {31'h0, bus.wr_ready}, 32'h0);
            tick();
        end
        bus.rd_req = 1'b0;
        #1;
        check("cont_accept",   {31'h0, bus.wr_ready}, 32'h1);
        check("cont_ram_addr", {18'h0, bus.ram_addr}, 32'd200);
        tick();
        bus.wr_valid = 1'b0;
        do_read(14'd200, 24'h55AA33);
        do_read(14'd16383, 24'h0F0F0F);
        tick();

        // Fill without reads
        bus.fill_invert = 1'b0;
        bus.fill_start  = 1'b1;
        tick();
        bus.fill_start = 1'b0;
        busy_cnt = 0; done_cnt = 0; bad_ready = 0;
        for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
            if (bus.fill_busy) busy_cnt++;
            if (bus.fill_busy && bus.wr_ready) bad_ready++;
            if (bus.fill_done) done_cnt++;
            else tick();
        end
        check("fill0_busy_cycles", busy_cnt, 32'd14400);
        check("fill0_done_seen",   done_cnt, 32'd1);
        check("fill0_done_busy",   {31'h0, bus.fill_busy}, 32'h0);
        check("fill0_wr_ready",    bad_ready, 32'd0);
        tick();
        check("fill0_done_pulse",  {31'h0, bus.fill_done}, 32'h0);
`ifdef VRAM_ARB_STATS_EN
        check("fill0_stat_stall", {16'h0, bus.stat_fill_stall}, 32'd0);
`endif
        do_read(14'd80,    24'h000000);
        do_read(14'd81,    24'hFFFFFF);
        do_read(14'd160,   24'h000000);
        do_read(14'd14399, 24'hFFFFFF);
        tick();

        // Fill with alternating reads of an out-of-range word, inverted halves
        bus.fill_invert = 1'b1;
        bus.fill_start  = 1'b1;
        tick();
        bus.fill_start  = 1'b0;
        bus.fill_invert = 1'b0;
        busy_cnt = 0; done_cnt = 0; rd_cycles = 0; tog = 1'b1;
        for (int i = 0; i < 40000 && done_cnt == 0; i++) begin
            if (bus.fill_done) begin
                done_cnt++;
                bus.rd_req = 1'b0;
            end else begin
                if (bus.fill_busy) busy_cnt++;
                bus.rd_req  = tog;
                bus.rd_addr = 14'd16383;
                if (tog) begin
                    exp_q.push_back(24'h0F0F0F);
                    if (bus.fill_busy) rd_cycles++;
                end
                tog = ~tog;
                tick();
            end
        end
        bus.rd_req = 1'b0;
        check("fill1_done_seen", done_cnt, 32'd1);
        checks++;
        if (busy_cnt < 28799 || busy_cnt > 28801) begin
            errors++;
            $display("FAIL fill1_busy_cycles: got %0d expected 28800+-1", busy_cnt);
        end
`ifdef VRAM_ARB_STATS_EN
        check("fill1_stat_stall", {16'h0, bus.stat_fill_stall}, rd_cycles);
`endif
        tick();
        do_read(14'd81, 24'h000000);
        do_read(14'd0,  24'hFFFFFF);
        do_read(14'd80, 24'hFFFFFF);
        tick();

        // Reset mid-fill at idx 500, then restart from idx 0
        bus.fill_start = 1'b1;
        tick();
        bus.fill_start = 1'b0;
        repeat (500) tick();
        check("abort_busy_before", {31'h0, bus.fill_busy}, 32'h1);
        check("abort_addr_before", {18'h0, bus.ram_addr},  32'd500);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, bus.fill_busy}, 32'h0);
        check("abort_done", {31'h0, bus.fill_done}, 32'h0);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.fill_done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 32'd0);
        bus.fill_start = 1'b1;
        tick();
        bus.fill_start = 1'b0;
        check("restart_addr",  {18'h0, bus.ram_addr},  32'd0);
        check("restart_we",    {31'h0, bus.ram_we},    32'h1);
        check("restart_wdata", {8'h0, bus.ram_wdata},  32'h0);
        done_cnt = 0;
        for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
            if (bus.fill_done) done_cnt++;
            else tick();
        end
        check("restart_done_seen", done_cnt, 32'd1);

        repeat (3) tick();
        check("rd_pending", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Single-port VRAM access controller in the clk_pixel domain. It shares one RAM port between three requesters: display scanout reads, a generic pixel-write handshake port, and a built-in split-screen fill sequencer.
- The fill sequencer replaces the ad-hoc button-driven fill loop. All VRAM traffic runs on clk_pixel.
- Sits between the video pattern generator (read side), control logic (write/fill side) and the VRAM array.

Parameters:
- VRAM_WIDTH, 160, VRAM columns.
- VRAM_HEIGHT, 90, VRAM rows.
- ADDR_W, 14, address width; must satisfy 2^ADDR_W >= VRAM_WIDTH*VRAM_HEIGHT.
- DATA_W, 24, pixel width (RGB888).
- FILL_FG, 24'hFFFFFF, colour for the right half (before inversion).
- FILL_BG, 24'h000000, colour for the left half (before inversion).

Ports:
- clk_pixel  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_req  in  1  scanout read request, one word per cycle.
- rd_addr  in  ADDR_W  scanout read address.
- rd_valid  out  1  rd_data valid; one cycle after an accepted rd_req.
- rd_data  out  DATA_W  read data (passthrough of ram_rdata).
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle when high together with wr_valid.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- fill_start  in  1  single-cycle pulse that starts a fill.
- fill_invert  in  1  swaps FG/BG halves; sampled on fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse after the last fill write.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; registered RAM, 1-cycle latency.

Behaviour:
- Reset values: rd_valid=0, fill_busy=0, fill_done=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, wr_ready=0. The fill FSM resets to IDLE.
- RAM control outputs are combinational from the current requests and FSM state.
- Fixed priority each cycle: rd_req, then fill, then wr.
- rd_req is always served: ram_en=1, ram_we=0, ram_addr=rd_addr.
- rd_valid is a registered copy of rd_req, so rd_data equals RAM[rd_addr] in the following cycle.
- wr_ready = !rd_req && !fill_busy. It is a combinational function of rd_req and the FSM state only, and never depends on wr_valid.
- Accepted write (wr_valid && wr_ready): ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
- A writer must hold wr_addr and wr_data stable until accepted. Unaccepted cycles have no side effect.
- Fill FSM states are IDLE and FILL.
  - IDLE to FILL on fill_start. Action: idx=0, col=0, latch fill_invert.
  - FILL issues one write in each cycle where rd_req=0. Address is idx. Data is FILL_FG if (col > VRAM_WIDTH/2) XOR invert, else FILL_BG.
  - Each issued write increments idx. col increments and wraps to 0 at VRAM_WIDTH-1. No division or modulo.
  - Cycles with rd_req=1 stall the FSM: idx and col hold.
  - FILL to IDLE after the write at idx = VRAM_WIDTH*VRAM_HEIGHT-1. fill_done pulses in the next cycle, and fill_busy drops in that same cycle.
  - fill_start while FILL is ignored. fill_start in the cycle fill_done is asserted starts a new fill.
- Simultaneous rd_req and wr_valid with no fill active: the read wins and wr_ready=0 that cycle.
- Addresses >= VRAM_WIDTH*VRAM_HEIGHT on the rd or wr port are passed through unchecked; range checking belongs to the caller.
- Asynchronous reset mid-fill aborts the fill: FSM to IDLE, no fill_done pulse, RAM contents undefined for the remainder.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined: adds outputs stat_wr_stall[15:0] and stat_fill_stall[15:0].
  - stat_wr_stall counts cycles with wr_valid && !wr_ready.
  - stat_fill_stall counts FILL cycles stalled by rd_req.
  - Both counters saturate at 16'hFFFF, clear on reset, and also clear on fill_start.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- Package vram_pkg holds:
  - VRAM_WIDTH, VRAM_HEIGHT, VRAM_SIZE, ADDR_W, DATA_W defaults;
  - fill state enum (FILL_IDLE, FILL_RUN);
  - FILL_FG/FILL_BG defaults.
- One sub-module, vram_fill_seq: the fill FSM plus idx/col counters, with a stall input and outputs addr, data, busy, done.
- Arbitration muxing stays in vram_arbiter.

Test Plan:
- Read latency: rd_req=1, rd_addr=5, RAM[5]=24'h123456 -> next cycle rd_valid=1, rd_data=24'h123456; wr_ready=0 during the request cycle.
- Write handshake: wr_valid=1, wr_addr=100, wr_data=24'hABCDEF, rd_req=0 -> wr_ready=1, ram_we=1, ram_addr=100; a later read of 100 returns 24'hABCDEF.
- Contention: rd_req and wr_valid both high for 3 cycles -> wr_ready=0 on all 3; the write is accepted on the first cycle with rd_req=0.
- Fill without reads: fill_start with fill_invert=0 -> fill_busy for exactly 14400 cycles.
  - RAM[80]=24'h000000, RAM[81]=24'hFFFFFF, RAM[160]=24'h000000.
  - fill_done pulses once; wr_ready=0 throughout.
- Fill with reads: rd_req toggling 1/0 and fill_invert=1 -> fill completes in 28800 cycles ±1; RAM[81]=24'h000000, RAM[0]=24'hFFFFFF.
- Reset mid-fill: assert rst_n=0 at idx 500 -> fill_busy=0 immediately, no fill_done; fill_start after release restarts from idx 0.
